id_stage: RTL and testbench

Instruction Decode stage of the veriRISCV 5-stage pipeline. It sits directly downstream of instruction fetch and consumes `if2id_valid`, `if2id_pc` and `if2id_instruction`. It decodes RV32I (optionally RV32M), reads the register file, and generates immediates and control signals. It registers everything into the `id2ex_*` pipeline stage and raises `if2id_stall` on load-use hazards or back-pressure from EX.

---
 rtl/id_stage_pkg.sv | 80 ++++++++
 rtl/id_stage_regfile.sv | 34 +++
 rtl/id_stage.sv | 205 ++++++++++++++++++++
 tb/tb_id_stage.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the veriRISCV ID stage: opcodes, ALU codes,
// immediate builders and the PC_RANGE/DATA_RANGE width macros.
`ifndef PC_RANGE
`define PC_RANGE XLEN-1:0
`endif
`ifndef DATA_RANGE
`define DATA_RANGE XLEN-1:0
`endif

package id_stage_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic [4:0] {
      ALU_ADD    = 5'd0,
      ALU_SUB    = 5'd1,
      ALU_SLL    = 5'd2,
      ALU_SLT    = 5'd3,
      ALU_SLTU   = 5'd4,
      ALU_XOR    = 5'd5,
      ALU_SRL    = 5'd6,
      ALU_SRA    = 5'd7,
      ALU_OR     = 5'd8,
      ALU_AND    = 5'd9,
      ALU_PASS_B = 5'd10,
      ALU_MUL    = 5'd11,
      ALU_MULH   = 5'd12,
      ALU_MULHSU = 5'd13,
      ALU_MULHU  = 5'd14,
      ALU_DIV    = 5'd15,
      ALU_DIVU   = 5'd16,
      ALU_REM    = 5'd17,
      ALU_REMU   = 5'd18
   } alu_op_e;

   // Shift encodings (funct3 001/101) are resolved by the caller against funct7.
   function automatic alu_op_e alu_base(input logic [2:0] f3);
      case (f3)
         3'b000:  return ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   function automatic logic signed [31:0] imm_i(input logic [31:0] ins);
      return {{20{ins[31]}}, ins[31:20]};
   endfunction

   function automatic logic signed [31:0] imm_s(input logic [31:0] ins);
      return {{20{ins[31]}}, ins[31:25], ins[11:7]};
   endfunction

   function automatic logic signed [31:0] imm_b(input logic [31:0] ins);
      return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
   endfunction

   function automatic logic signed [31:0] imm_u(input logic [31:0] ins);
      return {ins[31:12], 12'b0};
   endfunction

   function automatic logic signed [31:0] imm_j(input logic [31:0] ins);
      return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
   endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// Integer register file: two asynchronous read ports, one synchronous write
// port, x0 hardwired to zero, write-through bypass from the WB port.
module regfile #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              we,
   input  logic [REG_AW-1:0] wa,
   input  logic [XLEN-1:0]   wd,
   input  logic [REG_AW-1:0] ra1,
   input  logic [REG_AW-1:0] ra2,
   output logic [XLEN-1:0]   rd1,
   output logic [XLEN-1:0]   rd2
);

   logic [XLEN-1:0] mem [2**REG_AW];

   always_ff @(posedge clk) begin
      if (we && wa != '0)
         mem[wa] <= wd;
   end

   // A same-cycle WB write to the read index is returned before it lands.
   always_comb begin
      rd1 = mem[ra1];
      if (we && wa == ra1) rd1 = wd;
      if (ra1 == '0)       rd1 = '0;
      rd2 = mem[ra2];
      if (we && wa == ra2) rd2 = wd;
      if (ra2 == '0)       rd2 = '0;
   end

endmodule

// File: rtl/id_stage.sv
// veriRISCV instruction decode stage: RV32I decode, register read, load-use
// hazard detection and the id2ex pipeline register. RV32M via VERIRISCV_RV32M_EN.
module id_stage
   import id_stage_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if2id_valid,
   input  logic [`PC_RANGE]    if2id_pc,
   input  logic [31:0]         if2id_instruction,
   input  logic                id_flush,
   input  logic                id2ex_stall,
   input  logic                wb_reg_write,
   input  logic [REG_AW-1:0]   wb_rd,
   input  logic [`DATA_RANGE]  wb_data,
   output logic                if2id_stall,
   output logic                id2ex_valid,
   output logic [`PC_RANGE]    id2ex_pc,
   output logic [`DATA_RANGE]  id2ex_rs1_data,
   output logic [`DATA_RANGE]  id2ex_rs2_data,
   output logic [REG_AW-1:0]   id2ex_rs1,
   output logic [REG_AW-1:0]   id2ex_rs2,
   output logic [REG_AW-1:0]   id2ex_rd,
   output logic [XLEN-1:0]     id2ex_imm,
   output logic [4:0]          id2ex_alu_op,
   output logic                id2ex_alu_src1_pc,
   output logic                id2ex_alu_src2_imm,
   output logic                id2ex_reg_write,
   output logic                id2ex_mem_read,
   output logic                id2ex_mem_write,
   output logic [2:0]          id2ex_funct3,
   output logic                id2ex_branch,
   output logic                id2ex_jal,
   output logic                id2ex_jalr,
   output logic                id2ex_illegal
);

   logic [31:0]            ins;
   logic [6:0]             opcode, funct7;
   logic [2:0]             funct3_p0;
   logic [REG_AW-1:0]      rs1_p0, rs2_p0, rd_p0;
   logic [XLEN-1:0]        rs1_data_p0, rs2_data_p0;
   logic signed [31:0]     imm32_p0;
   logic signed [XLEN-1:0] imm_p0;
   alu_op_e                alu_op_p0;
   logic                   src1_pc_p0, src2_imm_p0, uses_rs1, uses_rs2;
   logic                   rw_p0, mr_p0, mw_p0, br_p0, jal_p0, jalr_p0, ill_p0;
   logic                   hazard;

   assign ins       = if2id_instruction;
   assign opcode    = ins[6:0];
   assign funct3_p0 = ins[14:12];
   assign funct7    = ins[31:25];
   assign rd_p0     = REG_AW'(ins[11:7]);
   assign rs1_p0    = REG_AW'(ins[19:15]);
   assign rs2_p0    = REG_AW'(ins[24:20]);
   assign imm_p0    = XLEN'(imm32_p0);

   regfile #(.XLEN(XLEN), .REG_AW(REG_AW)) u_regfile (
      .clk (clk),
      .we  (wb_reg_write),
      .wa  (wb_rd),
      .wd  (wb_data),
      .ra1 (rs1_p0),
      .ra2 (rs2_p0),
      .rd1 (rs1_data_p0),
      .rd2 (rs2_data_p0)
   );

   // Raw decode; side effects of an illegal encoding are masked further down.
   always_comb begin
      alu_op_p0   = ALU_ADD;
      src1_pc_p0  = 1'b0;
      src2_imm_p0 = 1'b0;
      uses_rs1    = 1'b0;
      uses_rs2    = 1'b0;
      rw_p0       = 1'b0;
      mr_p0       = 1'b0;
      mw_p0       = 1'b0;
      br_p0       = 1'b0;
      jal_p0      = 1'b0;
      jalr_p0     = 1'b0;
      ill_p0      = 1'b0;
      imm32_p0    = imm_i(ins);
      case (opcode)
         OPC_LUI: begin
            imm32_p0 = imm_u(ins); alu_op_p0 = ALU_PASS_B;
            src2_imm_p0 = 1'b1; rw_p0 = 1'b1;
         end
         OPC_AUIPC: begin
            imm32_p0 = imm_u(ins); src1_pc_p0 = 1'b1;
            src2_imm_p0 = 1'b1; rw_p0 = 1'b1;
         end
         OPC_JAL: begin
            imm32_p0 = imm_j(ins); src1_pc_p0 = 1'b1;
            src2_imm_p0 = 1'b1; rw_p0 = 1'b1; jal_p0 = 1'b1;
         end
         OPC_JALR: begin
            uses_rs1 = 1'b1; src2_imm_p0 = 1'b1; rw_p0 = 1'b1; jalr_p0 = 1'b1;
            ill_p0 = (funct3_p0 != 3'b000);
         end
         OPC_BRANCH: begin
            imm32_p0 = imm_b(ins); alu_op_p0 = ALU_SUB;
            uses_rs1 = 1'b1; uses_rs2 = 1'b1; br_p0 = 1'b1;
            ill_p0 = (funct3_p0 == 3'b010) || (funct3_p0 == 3'b011);
         end
         OPC_LOAD: begin
            uses_rs1 = 1'b1; src2_imm_p0 = 1'b1; rw_p0 = 1'b1; mr_p0 = 1'b1;
            ill_p0 = (funct3_p0 == 3'b011) || (funct3_p0[2:1] == 2'b11);
         end
         OPC_STORE: begin
            imm32_p0 = imm_s(ins); uses_rs1 = 1'b1; uses_rs2 = 1'b1;
            src2_imm_p0 = 1'b1; mw_p0 = 1'b1;
            ill_p0 = (funct3_p0[2] == 1'b1) || (funct3_p0 == 3'b011);
         end
         OPC_OPIMM: begin
            uses_rs1 = 1'b1; src2_imm_p0 = 1'b1; rw_p0 = 1'b1;
            alu_op_p0 = alu_base(funct3_p0);
            if (funct3_p0 == 3'b001)
               ill_p0 = (funct7 != 7'b0000000);
            else if (funct3_p0 == 3'b101) begin
               if (funct7 == 7'b0100000)      alu_op_p0 = ALU_SRA;
               else if (funct7 != 7'b0000000) ill_p0 = 1'b1;
            end
         end
         OPC_OP: begin
            uses_rs1 = 1'b1; uses_rs2 = 1'b1; rw_p0 = 1'b1;
            case (funct7)
               7'b0000000: alu_op_p0 = alu_base(funct3_p0);
               7'b0100000: begin
                  if (funct3_p0 == 3'b000)      alu_op_p0 = ALU_SUB;
                  else if (funct3_p0 == 3'b101) alu_op_p0 = ALU_SRA;
                  else                          ill_p0 = 1'b1;
               end
`ifdef VERIRISCV_RV32M_EN
               7'b0000001: begin
                  case (funct3_p0)
                     3'b000:  alu_op_p0 = ALU_MUL;
                     3'b001:  alu_op_p0 = ALU_MULH;
                     3'b010:  alu_op_p0 = ALU_MULHSU;
                     3'b011:  alu_op_p0 = ALU_MULHU;
                     3'b100:  alu_op_p0 = ALU_DIV;
                     3'b101:  alu_op_p0 = ALU_DIVU;
                     3'b110:  alu_op_p0 = ALU_REM;
                     default: alu_op_p0 = ALU_REMU;
                  endcase
               end
`endif
               default: ill_p0 = 1'b1;
            endcase
         end
         OPC_FENCE, OPC_SYSTEM: ;
         default: ill_p0 = 1'b1;
      endcase
   end

   assign hazard = if2id_valid & id2ex_valid & id2ex_mem_read & (id2ex_rd != '0) &
                   ((uses_rs1 & (rs1_p0 == id2ex_rd)) | (uses_rs2 & (rs2_p0 == id2ex_rd)));

   assign if2id_stall = hazard | id2ex_stall;

   // ---- id2ex stage boundary: control (reset, flushed, bubbled) ----
   always_ff @(posedge clk) begin
      if (rst || id_flush || (!id2ex_stall && hazard)) begin
         id2ex_valid     <= 1'b0;
         id2ex_reg_write <= 1'b0;
         id2ex_mem_read  <= 1'b0;
         id2ex_mem_write <= 1'b0;
         id2ex_branch    <= 1'b0;
         id2ex_jal       <= 1'b0;
         id2ex_jalr      <= 1'b0;
         id2ex_illegal   <= 1'b0;
      end else if (!id2ex_stall) begin
         id2ex_valid     <= if2id_valid;
         id2ex_reg_write <= if2id_valid & rw_p0 & ~ill_p0 & (rd_p0 != '0);
         id2ex_mem_read  <= if2id_valid & mr_p0 & ~ill_p0;
         id2ex_mem_write <= if2id_valid & mw_p0 & ~ill_p0;
         id2ex_branch    <= if2id_valid & br_p0 & ~ill_p0;
         id2ex_jal       <= if2id_valid & jal_p0 & ~ill_p0;
         id2ex_jalr      <= if2id_valid & jalr_p0 & ~ill_p0;
         id2ex_illegal   <= if2id_valid & ill_p0;
      end
   end

   // ---- id2ex stage boundary: datapath (no reset) ----
   always_ff @(posedge clk) begin
      if (!id2ex_stall) begin
         id2ex_pc           <= if2id_pc;
         id2ex_rs1_data     <= rs1_data_p0;
         id2ex_rs2_data     <= rs2_data_p0;
         id2ex_rs1          <= rs1_p0;
         id2ex_rs2          <= rs2_p0;
         id2ex_rd           <= rd_p0;
         id2ex_imm          <= imm_p0;
         id2ex_alu_op       <= alu_op_p0;
         id2ex_alu_src1_pc  <= src1_pc_p0;
         id2ex_alu_src2_imm <= src2_imm_p0;
         id2ex_funct3       <= funct3_p0;
      end
   end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: directed instruction vectors push expected
// id2ex contents and if2id_stall; a negedge monitor pops and compares.
module tb_id_stage;
   import id_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if2id_valid = 1'b0;
   logic [31:0] if2id_pc = '0;
   logic [31:0] if2id_instruction = '0;
   logic        id_flush = 1'b0;
   logic        id2ex_stall = 1'b0;
   logic        wb_reg_write = 1'b0;
   logic [4:0]  wb_rd = '0;
   logic [31:0] wb_data = '0;
   logic        if2id_stall, id2ex_valid;
   logic [31:0] id2ex_pc, id2ex_rs1_data, id2ex_rs2_data, id2ex_imm;
   logic [4:0]  id2ex_rs1, id2ex_rs2, id2ex_rd, id2ex_alu_op;
   logic        id2ex_alu_src1_pc, id2ex_alu_src2_imm, id2ex_reg_write;
   logic        id2ex_mem_read, id2ex_mem_write, id2ex_branch, id2ex_jal;
   logic        id2ex_jalr, id2ex_illegal;
   logic [2:0]  id2ex_funct3;

   id_stage dut (
      .clk(clk), .rst(rst), .if2id_valid(if2id_valid), .if2id_pc(if2id_pc),
      .if2id_instruction(if2id_instruction), .id_flush(id_flush),
      .id2ex_stall(id2ex_stall), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
      .wb_data(wb_data), .if2id_stall(if2id_stall), .id2ex_valid(id2ex_valid),
      .id2ex_pc(id2ex_pc), .id2ex_rs1_data(id2ex_rs1_data),
      .id2ex_rs2_data(id2ex_rs2_data), .id2ex_rs1(id2ex_rs1), .id2ex_rs2(id2ex_rs2),
      .id2ex_rd(id2ex_rd), .id2ex_imm(id2ex_imm), .id2ex_alu_op(id2ex_alu_op),
      .id2ex_alu_src1_pc(id2ex_alu_src1_pc), .id2ex_alu_src2_imm(id2ex_alu_src2_imm),
      .id2ex_reg_write(id2ex_reg_write), .id2ex_mem_read(id2ex_mem_read),
      .id2ex_mem_write(id2ex_mem_write), .id2ex_funct3(id2ex_funct3),
      .id2ex_branch(id2ex_branch), .id2ex_jal(id2ex_jal), .id2ex_jalr(id2ex_jalr),
      .id2ex_illegal(id2ex_illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      string       nm;
      bit          v;
      logic [31:0] pc, imm, d1, d2;
      logic [4:0]  rd, rs1, rs2, alu;
      logic [2:0]  f3;
      bit          ci, cd, s1, s2, rw, mr, mw, br, jl, jr, il;
   } exp_t;

   typedef struct {
      int    cyc;
      string nm;
      bit    st;
   } sexp_t;

   exp_t  oq[$];
   sexp_t sq[$];
   exp_t  last;
   int    cyc = 0;
   int    n_vec = 0;
   int    n_miss = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t mk(input string nm, input logic [31:0] pc,
         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
         input logic [31:0] imm, input bit ci, input logic [4:0] alu,
         input bit s1, input bit s2, input bit rw, input bit mr, input bit mw,
         input logic [2:0] f3, input bit br, input bit jl, input bit jr, input bit il,
         input bit cd, input logic [31:0] d1, input logic [31:0] d2);
      exp_t e;
      e.cyc = 0; e.nm = nm; e.v = 1'b1; e.pc = pc; e.rd = rd; e.rs1 = rs1;
      e.rs2 = rs2; e.imm = imm; e.ci = ci; e.alu = alu; e.s1 = s1; e.s2 = s2;
      e.rw = rw; e.mr = mr; e.mw = mw; e.f3 = f3; e.br = br; e.jl = jl;
      e.jr = jr; e.il = il; e.cd = cd; e.d1 = d1; e.d2 = d2;
      return e;
   endfunction

   function automatic exp_t bub(input string nm);
      exp_t e;
      e = mk(nm, '0, '0, '0, '0, '0, 1'b0, '0, 0, 0, 0, 0, 0, '0, 0, 0, 0, 0, 1'b0, '0, '0);
      e.v = 1'b0;
      return e;
   endfunction

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
      if (act !== req) begin
         n_miss++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   task automatic check_out(input exp_t e);
      cmp({e.nm, ".valid"},  32'(id2ex_valid),     32'(e.v));
      cmp({e.nm, ".rw"},     32'(id2ex_reg_write), 32'(e.rw));
      cmp({e.nm, ".mr"},     32'(id2ex_mem_read),  32'(e.mr));
      cmp({e.nm, ".mw"},     32'(id2ex_mem_write), 32'(e.mw));
      cmp({e.nm, ".branch"}, 32'(id2ex_branch),    32'(e.br));
      cmp({e.nm, ".jal"},    32'(id2ex_jal),       32'(e.jl));
      cmp({e.nm, ".jalr"},   32'(id2ex_jalr),      32'(e.jr));
      if (e.v) begin
         cmp({e.nm, ".illegal"}, 32'(id2ex_illegal), 32'(e.il));
         cmp({e.nm, ".pc"},      id2ex_pc,            e.pc);
         cmp({e.nm, ".rd"},      32'(id2ex_rd),       32'(e.rd));
         cmp({e.nm, ".rs1"},     32'(id2ex_rs1),      32'(e.rs1));
         cmp({e.nm, ".rs2"},     32'(id2ex_rs2),      32'(e.rs2));
         cmp({e.nm, ".funct3"},  32'(id2ex_funct3),   32'(e.f3));
         if (!e.il) begin
            cmp({e.nm, ".alu_op"},   32'(id2ex_alu_op),       32'(e.alu));
            cmp({e.nm, ".src1_pc"},  32'(id2ex_alu_src1_pc),  32'(e.s1));
            cmp({e.nm, ".src2_imm"}, 32'(id2ex_alu_src2_imm), 32'(e.s2));
         end
         if (e.ci) cmp({e.nm, ".imm"}, id2ex_imm, e.imm);
         if (e.cd) begin
            cmp({e.nm, ".rs1_data"}, id2ex_rs1_data, e.d1);
            cmp({e.nm, ".rs2_data"}, id2ex_rs2_data, e.d2);
         end
      end
   endtask

   // Monitor: each cycle, compare whatever entries are due at this negedge.
   initial begin
      forever begin
         @(negedge clk);
         while (sq.size() > 0 && sq[0].cyc <= cyc) begin
            sexp_t s;
            s = sq.pop_front();
            n_vec++;
            cmp({s.nm, ".if2id_stall"}, 32'(if2id_stall), 32'(s.st));
         end
         while (oq.size() > 0 && oq[0].cyc <= cyc) begin
            exp_t e;
            e = oq.pop_front();
            n_vec++;
            check_out(e);
         end
      end
   end

   task automatic drive(input bit r, input bit v, input logic [31:0] pc,
         input logic [31:0] ins, input bit fl, input bit st, input bit we,
         input logic [4:0] wrd, input logic [31:0] wd, input bit exp_st, input exp_t e);
      sexp_t s;
      @(posedge clk);
      #1;
      rst = r; if2id_valid = v; if2id_pc = pc; if2id_instruction = ins;
      id_flush = fl; id2ex_stall = st; wb_reg_write = we; wb_rd = wrd; wb_data = wd;
      s.cyc = cyc; s.nm = e.nm; s.st = exp_st;
      sq.push_back(s);
      e.cyc = cyc + 1;
      oq.push_back(e);
      last = e;
   endtask

   localparam logic [31:0] X1 = 32'h1111_1111;
   localparam logic [31:0] X2 = 32'h2222_2222;
   localparam logic [31:0] X5 = 32'h5555_5555;

   initial begin
      exp_t held;
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, bub("reset0"));
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, bub("reset1"));
      drive(0, 0, 0, 0, 0, 0, 1, 5'd1, X1, 0, bub("wb_x1"));
      drive(0, 0, 0, 0, 0, 0, 1, 5'd2, X2, 0, bub("wb_x2"));
      drive(0, 0, 0, 0, 0, 0, 1, 5'd5, X5, 0, bub("wb_x5"));
      drive(0, 1, 32'h100, 32'h0050_0093, 0, 0, 0, 0, 0, 0,
            mk("addi", 32'h100, 1, 0, 5, 32'd5, 1, ALU_ADD, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, X5));
      drive(0, 1, 32'h104, 32'h0000_A103, 0, 0, 0, 0, 0, 0,
            mk("lw", 32'h104, 2, 1, 0, 32'd0, 1, ALU_ADD, 0, 1, 1, 1, 0, 2, 0, 0, 0, 0, 1, X1, 0));
      drive(0, 1, 32'h108, 32'h0021_01B3, 0, 0, 0, 0, 0, 1, bub("loaduse_bubble"));
      drive(0, 1, 32'h108, 32'h0021_01B3, 0, 0, 0, 0, 0, 0,
            mk("add_after_bubble", 32'h108, 3, 2, 2, 0, 0, ALU_ADD, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, X2, X2));
      drive(0, 1, 32'h10C, 32'h0002_8333, 0, 0, 1, 5'd5, 32'hDEAD_BEEF, 0,
            mk("bypass", 32'h10C, 6, 5, 0, 0, 0, ALU_ADD, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0));
      drive(0, 1, 32'h110, 32'h0000_03B3, 0, 0, 1, 5'd0, 32'hDEAD_BEEF, 0,
            mk("wb_x0", 32'h110, 7, 0, 0, 0, 0, ALU_ADD, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      held = last;
      held.nm = "ex_stall_hold";
      drive(0, 1, 32'h114, 32'h1234_54B7, 0, 1, 0, 0, 0, 1, held);
      drive(0, 1, 32'h114, 32'h1234_54B7, 1, 1, 0, 0, 0, 1, bub("flush_over_stall"));
      drive(0, 1, 32'h200, 32'hFE00_0EE3, 0, 0, 0, 0, 0, 0,
            mk("beq", 32'h200, 29, 0, 0, 32'hFFFF_FFFC, 1, ALU_SUB, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
      drive(0, 1, 32'h204, 32'h0080_006F, 0, 0, 0, 0, 0, 0,
            mk("jal", 32'h204, 0, 0, 8, 32'd8, 1, ALU_ADD, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
`ifdef VERIRISCV_RV32M_EN
      drive(0, 1, 32'h208, 32'h0220_8033, 0, 0, 0, 0, 0, 0,
            mk("mul", 32'h208, 0, 1, 2, 0, 0, ALU_MUL, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, X1, X2));
`else
      drive(0, 1, 32'h208, 32'h0220_8033, 0, 0, 0, 0, 0, 0,
            mk("mul_illegal", 32'h208, 0, 1, 2, 0, 0, ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, X1, X2));
`endif
      drive(0, 1, 32'h20C, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0,
            mk("bad_opcode", 32'h20C, 31, 31, 31, 0, 0, ALU_ADD, 0, 0, 0, 0, 0, 7, 0, 0, 0, 1, 0, 0, 0));
      drive(0, 1, 32'h210, 32'h0020_A223, 0, 0, 0, 0, 0, 0,
            mk("sw", 32'h210, 4, 1, 2, 32'd4, 1, ALU_ADD, 0, 1, 0, 0, 1, 2, 0, 0, 0, 0, 1, X1, X2));
      drive(0, 1, 32'h214, 32'h1234_54B7, 0, 0, 0, 0, 0, 0,
            mk("lui", 32'h214, 9, 8, 3, 32'h1234_5000, 1, ALU_PASS_B, 0, 1, 1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0));
      drive(0, 1, 32'h300, 32'h0000_A103, 0, 0, 0, 0, 0, 0,
            mk("lw2", 32'h300, 2, 1, 0, 32'd0, 1, ALU_ADD, 0, 1, 1, 1, 0, 2, 0, 0, 0, 0, 1, X1, 0));
      drive(0, 1, 32'h304, 32'h0021_01B3, 1, 0, 0, 0, 0, 1, bub("flush_during_hazard"));
      drive(0, 1, 32'h304, 32'h0021_01B3, 0, 0, 0, 0, 0, 0,
            mk("add_after_flush", 32'h304, 3, 2, 2, 0, 0, ALU_ADD, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, X2, X2));
      drive(1, 1, 32'h308, 32'h0021_01B3, 0, 1, 0, 0, 0, 1, bub("rst_over_stall"));
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, bub("idle"));

      for (int i = 0; i < 10 && (oq.size() > 0 || sq.size() > 0); i++)
         @(posedge clk);
      if (oq.size() > 0 || sq.size() > 0) begin
         n_miss++;
         $display("FAIL drain pending=%0d required=0", oq.size() + sq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
